// File: rtl/s_term_mon_pkg.sv
// Shared types and helpers for the south-terminal wire monitor.
// Optional timestamp words are enabled by STERM_MON_TIMESTAMP_EN.
package s_term_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } mon_state_e;

  // Bit offsets of each wire group inside the packed s_wires bus.
  localparam int S1END_OFF  = 0;
  localparam int S2MID_OFF  = 4;
  localparam int S2END_OFF  = 12;
  localparam int S4END_OFF  = 20;
  localparam int SS4END_OFF = 36;

  localparam int TS_W = 16;

  function automatic int nwords(input int width, input int word_w);
    return (width + word_w - 1) / word_w;
  endfunction

  function automatic int ts_words(input int word_w);
    return (TS_W + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/s_term_mon_word_sel.sv
// Readout word mux: picks word i_idx out of the snapshot frame.
// Indices beyond the frame read as zero.
module s_term_mon_word_sel
  import s_term_mon_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int NW     = 7,
  parameter int IDX_W  = 3
) (
  input  logic [NW*WORD_W-1:0] i_frame,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [WORD_W-1:0]    o_word
);

  always_comb begin
    o_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_word = i_frame[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/s_term_wire_monitor.sv
// One-shot snapshot capture of the south-arriving wire ENDs, drained as words.
// Define STERM_MON_TIMESTAMP_EN to append a 16-bit capture timestamp to the stream.
//
// Handshake: a word transfers on a UserCLK edge where rd_valid & rd_ready are both
// high; while rd_valid is high and rd_ready low, rd_data and rd_last hold stable,
// and rd_valid never drops before the word is taken (except on reset).
module s_term_wire_monitor
  import s_term_mon_pkg::*;
#(
  parameter int WIDTH  = 52,
  parameter int WORD_W = 8,
  parameter int MISS_W = 8
) (
  input  logic              UserCLK,
  input  logic              UserRSTn,
  input  logic [WIDTH-1:0]  s_wires,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic              ext_trig,
  input  logic              arm,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              armed,
  output logic              busy,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int NWORDS = nwords(WIDTH, WORD_W);
`ifdef STERM_MON_TIMESTAMP_EN
  localparam int PAD_W  = NWORDS * WORD_W;
  localparam int TOTAL  = NWORDS + ts_words(WORD_W);
`else
  localparam int TOTAL  = NWORDS;
`endif
  localparam int FRAME_W = TOTAL * WORD_W;
  localparam int IDX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  mon_state_e         r_state;
  mon_state_e         w_next;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_shadow;
  logic [IDX_W-1:0]   r_idx;
  logic [MISS_W-1:0]  r_miss;
  logic               w_chg;
  logic               w_trig;
  logic               w_capture;
  logic               w_accept;
  logic               w_last;
  logic               w_valid;
  logic [FRAME_W-1:0] w_frame;
  logic [WORD_W-1:0]  w_word;

  assign w_chg  = |((s_wires ^ r_prev) & trig_mask);
  assign w_trig = ext_trig | w_chg;
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_next = ARMED;
        end
      end
      ARMED: begin
        if (w_trig) begin
          w_capture = 1'b1;
          w_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      r_prev   <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_miss   <= '0;
    end else begin
      r_prev <= s_wires;
      if (w_capture) begin
        r_shadow <= s_wires;
        r_idx    <= '0;
      end else if (w_accept) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      // Triggers that arrive while a snapshot is draining are lost; count them.
      if ((r_state == DRAIN) && w_trig && (r_miss != '1)) begin
        r_miss <= r_miss + MISS_W'(1);
      end
    end
  end

`ifdef STERM_MON_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ts_cap;

  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      r_ts     <= '0;
      r_ts_cap <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_capture) begin
        r_ts_cap <= r_ts;
      end
    end
  end
`endif

  // Frame = zero-padded snapshot, followed (optionally) by the timestamp words.
  always_comb begin
    w_frame            = '0;
    w_frame[WIDTH-1:0] = r_shadow;
`ifdef STERM_MON_TIMESTAMP_EN
    w_frame[PAD_W +: TS_W] = r_ts_cap;
`endif
  end

  s_term_mon_word_sel #(
    .WORD_W (WORD_W),
    .NW     (TOTAL),
    .IDX_W  (IDX_W)
  ) u_word_sel (
    .i_frame (w_frame),
    .i_idx   (r_idx),
    .o_word  (w_word)
  );

  assign w_valid   = (r_state == DRAIN);
  assign rd_valid  = w_valid;
  assign rd_data   = w_valid ? w_word : '0;
  assign rd_last   = w_valid & w_last;
  assign armed     = (r_state == ARMED);
  assign busy      = w_valid;
  assign miss_cnt  = r_miss;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_s_term_wire_monitor.sv
// Self-checking bench for s_term_wire_monitor (default build, 52 wires, 8-bit words).
module tb_s_term_wire_monitor;

  logic        UserCLK;
  logic        UserRSTn;
  logic [51:0] s_wires;
  logic [51:0] trig_mask;
  logic        ext_trig;
  logic        arm;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        armed;
  logic        busy;
  logic [7:0]  miss_cnt;
  logic [1:0]  dbg_state;

  s_term_wire_monitor dut (
    .UserCLK   (UserCLK),
    .UserRSTn  (UserRSTn),
    .s_wires   (s_wires),
    .trig_mask (trig_mask),
    .ext_trig  (ext_trig),
    .arm       (arm),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .armed     (armed),
    .busy      (busy),
    .miss_cnt  (miss_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [51:0]     wires;
    logic [6:0][7:0] w;
  } vec_t;
  vec_t tbl[5];

  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic push_vec(input int i);
    logic [8:0] e;
    for (int k = 0; k < 7; k++) begin
      e[8]   = (k == 6);
      e[7:0] = tbl[i].w[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cycles++;
    end
    rd_ready = 1'b0;
    check("drain_done", {63'd0, busy}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard / stability monitor
  logic [8:0] hold_v;
  logic       hold_f = 1'b0;
  always @(negedge UserCLK) begin
    logic [8:0] e;
    if (hold_f && rd_valid) check("stall_hold", {55'd0, rd_last, rd_data}, {55'd0, hold_v});
    hold_f = rd_valid && !rd_ready && UserRSTn;
    hold_v = {rd_last, rd_data};
    if (rd_valid && rd_ready && UserRSTn) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none", {rd_last, rd_data});
      end else begin
        e = exp_q.pop_front();
        check("word", {55'd0, rd_last, rd_data}, {55'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    tbl[0].wires = 52'h0_0000_0000_000F;
    tbl[0].w     = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
    tbl[1].wires = 52'hF_FFFF_FFFF_FFFF;
    tbl[1].w     = {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2].wires = 52'h1_2345_6789_ABCD;
    tbl[2].w     = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD};
    tbl[3].wires = 52'hA_5A5A_5A5A_5A5A;
    tbl[3].w     = {8'h0A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    tbl[4].wires = 52'h0_0000_0030_0000;
    tbl[4].w     = {8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00};

    UserRSTn = 1'b0; s_wires = '0; trig_mask = '0;
    ext_trig = 1'b0; arm = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_last",  {63'd0, rd_last},  64'd0);
    check("rst_data",  {56'd0, rd_data},  64'd0);
    check("rst_armed", {63'd0, armed},    64'd0);
    check("rst_busy",  {63'd0, busy},     64'd0);
    check("rst_miss",  {56'd0, miss_cnt}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    UserRSTn = 1'b1;
    tick();

    // table-driven captures: vector 0 with ready held high, others with random stalls
    for (int i = 0; i < 4; i++) begin
      s_wires = tbl[i].wires;
      tick();
      do_arm();
      check("armed_after_arm", {63'd0, armed}, 64'd1);
      ext_trig = 1'b1;
      push_vec(i);
      tick();
      ext_trig = 1'b0;
      check("busy_after_trig", {63'd0, busy}, 64'd1);
      check("state_drain", {62'd0, dbg_state}, 64'd2);
      s_wires = ~tbl[i].wires;
      drain(i != 0, 400, cyc);
      if (i == 0) check("drain_cycles", 64'(cyc), 64'd7);
      check("one_shot_idle", {62'd0, dbg_state}, 64'd0);
    end

    // change trigger: only masked bit 20 captures
    trig_mask = 52'd1 << 20;
    s_wires = '0;
    tick(); tick();
    do_arm();
    s_wires[21] = 1'b1;
    tick();
    check("mask_ignore_b21", {63'd0, busy}, 64'd0);
    check("mask_still_armed", {63'd0, armed}, 64'd1);
    s_wires[20] = 1'b1;
    push_vec(4);
    tick();
    check("mask_capture_b20", {63'd0, busy}, 64'd1);
    trig_mask = '0;
    drain(1'b0, 400, cyc);

    // stall plus lost triggers while draining
    s_wires = tbl[2].wires;
    do_arm();
    ext_trig = 1'b1;
    push_vec(2);
    tick();
    ext_trig = 1'b0;
    rd_ready = 1'b0;
    repeat (5) tick();
    check("stall_valid", {63'd0, rd_valid}, 64'd1);
    check("stall_word0", {56'd0, rd_data}, {56'd0, tbl[2].w[0]});
    for (int p = 0; p < 300; p++) begin
      ext_trig = 1'b1;
      tick();
      ext_trig = 1'b0;
      tick();
      if (p == 9) check("miss_10", {56'd0, miss_cnt}, 64'd10);
    end
    check("miss_sat", {56'd0, miss_cnt}, 64'd255);
    drain(1'b1, 400, cyc);
    check("miss_kept", {56'd0, miss_cnt}, 64'd255);

    // arm and trigger together from IDLE: arms only
    s_wires = tbl[1].wires;
    arm = 1'b1; ext_trig = 1'b1;
    tick();
    arm = 1'b0; ext_trig = 1'b0;
    check("armtrig_armed", {63'd0, armed}, 64'd1);
    check("armtrig_busy", {63'd0, busy}, 64'd0);
    tick();
    check("armtrig_hold", {63'd0, armed}, 64'd1);
    ext_trig = 1'b1;
    push_vec(1);
    tick();
    ext_trig = 1'b0;
    check("armtrig_capture", {63'd0, busy}, 64'd1);
    drain(1'b1, 400, cyc);

    // reset in the middle of a drain
    s_wires = tbl[3].wires;
    do_arm();
    ext_trig = 1'b1;
    push_vec(3);
    tick();
    ext_trig = 1'b0;
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    check("pre_reset_left", 64'(exp_q.size()), 64'd4);
    UserRSTn = 1'b0;
    tick();
    check("midrst_valid", {63'd0, rd_valid}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    check("midrst_miss", {56'd0, miss_cnt}, 64'd0);
    check("midrst_last", {63'd0, rd_last}, 64'd0);
    exp_q.delete();
    UserRSTn = 1'b1;
    s_wires = tbl[0].wires;
    tick();
    do_arm();
    ext_trig = 1'b1;
    push_vec(0);
    tick();
    ext_trig = 1'b0;
    check("restart_word0", {56'd0, rd_data}, 64'h0F);
    drain(1'b0, 400, cyc);
    check("restart_cycles", 64'(cyc), 64'd7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
